// File: rtl/mcdt_arbiter.sv
// -----------------------------------------------------------------------------
// mcdt_arbiter
//   Three-channel output arbiter for the MCDT datapath. Each cycle it picks one
//   requesting, enabled channel, pops one word from that channel's FIFO and
//   loads it into a registered output stage along with its channel id. The
//   pick is either round-robin (starting after the last winner) or fixed
//   priority (ch0 > ch1 > ch2). The output stage honours downstream
//   back-pressure and sustains one word per cycle.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   cfg_en_i[2:0]           per-channel enable
//   cfg_rr_i                1 = round-robin, 0 = fixed priority
//   chN_req_i               channel FIFO non-empty
//   chN_data_i[DW-1:0]      channel FIFO head word
//   chN_ack_o               pop strobe (combinational, one-hot or zero)
//   mcdt_rdy_i              downstream ready
//   mcdt_data_o/val_o/id_o  registered output word, valid and source id
// -----------------------------------------------------------------------------

// Per-channel slice: qualifies the request with its enable and gates the pop
// strobe with the global grant decision.
module mcdt_arb_lane (
    input  logic i_req,
    input  logic i_en,
    input  logic i_sel,
    input  logic i_grant,
    output logic o_elig,
    output logic o_ack
);
    assign o_elig = i_req & i_en;
    assign o_ack  = i_grant & i_sel;
endmodule

module mcdt_arbiter #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [2:0]    cfg_en_i,
    input  logic          cfg_rr_i,
    input  logic          ch0_req_i,
    input  logic          ch1_req_i,
    input  logic          ch2_req_i,
    input  logic [DW-1:0] ch0_data_i,
    input  logic [DW-1:0] ch1_data_i,
    input  logic [DW-1:0] ch2_data_i,
    output logic          ch0_ack_o,
    output logic          ch1_ack_o,
    output logic          ch2_ack_o,
    input  logic          mcdt_rdy_i,
    output logic [DW-1:0] mcdt_data_o,
    output logic          mcdt_val_o,
    output logic [1:0]    mcdt_id_o
);
    localparam int NUM_CH = 3;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_ack;
    logic [1:0]        w_start;
    logic [1:0]        w_idx;
    logic              w_found;
    logic              w_free;
    logic              w_grant;
    logic [DW-1:0]     w_gdata;

    logic [DW-1:0]     r_data;
    logic              r_val;
    logic [1:0]        r_id;
    logic [1:0]        r_last;

    assign w_req = {ch2_req_i, ch1_req_i, ch0_req_i};

    // The output slot can take a new word if it is empty or being drained
    // on this very edge.
    assign w_free = ~r_val | mcdt_rdy_i;

    // Round-robin search begins one past the previous winner, wrapping 2 -> 0.
    assign w_start = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;

    always_comb begin
        logic [2:0] v_cand;
        w_idx   = 2'd0;
        w_found = 1'b0;
        v_cand  = 3'd0;
        if (cfg_rr_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                v_cand = {1'b0, w_start} + 3'(k);
                if (v_cand >= 3'd3) v_cand = v_cand - 3'd3;
                if (!w_found && w_elig[v_cand[1:0]]) begin
                    w_found = 1'b1;
                    w_idx   = v_cand[1:0];
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!w_found && w_elig[k]) begin
                    w_found = 1'b1;
                    w_idx   = 2'(k);
                end
            end
        end
    end

    // Reset suppresses the pop so no FIFO word is lost while the output
    // register is being cleared.
    assign w_grant = w_free & w_found & ~rst_i;

    always_comb begin
        w_sel = '0;
        w_sel[w_idx] = 1'b1;
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        mcdt_arb_lane u_lane (
            .i_req   (w_req[n]),
            .i_en    (cfg_en_i[n]),
            .i_sel   (w_sel[n]),
            .i_grant (w_grant),
            .o_elig  (w_elig[n]),
            .o_ack   (w_ack[n])
        );
    end

    assign ch0_ack_o = w_ack[0];
    assign ch1_ack_o = w_ack[1];
    assign ch2_ack_o = w_ack[2];

    always_comb begin
        case (w_idx)
            2'd1:    w_gdata = ch1_data_i;
            2'd2:    w_gdata = ch2_data_i;
            default: w_gdata = ch0_data_i;
        endcase
    end

    // last_grant follows every grant, in either mode, so a switch to
    // round-robin resumes after the most recent winner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_val  <= 1'b0;
            r_data <= '0;
            r_id   <= 2'd0;
            r_last <= 2'd2;
        end else if (w_grant) begin
            r_val  <= 1'b1;
            r_data <= w_gdata;
            r_id   <= w_idx;
            r_last <= w_idx;
        end else if (w_free) begin
            r_val  <= 1'b0;
        end
    end

    assign mcdt_data_o = r_data;
    assign mcdt_val_o  = r_val;
    assign mcdt_id_o   = r_id;

endmodule

// File: tb/tb_mcdt_arbiter.sv
module tb_mcdt_arbiter;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, rr, rdy;
    logic [2:0]    en;
    logic          ch0_req, ch1_req, ch2_req;
    logic [DW-1:0] ch0_data, ch1_data, ch2_data;
    logic          ch0_ack, ch1_ack, ch2_ack;
    logic [DW-1:0] mcdt_data;
    logic          mcdt_val;
    logic [1:0]    mcdt_id;

    always #5 clk = ~clk;

    // FIFO models: depth and head index per channel; word = {C0+ch, index}.
    int cnt[3];
    int head[3];

    assign ch0_req  = cnt[0] > 0;
    assign ch1_req  = cnt[1] > 0;
    assign ch2_req  = cnt[2] > 0;
    assign ch0_data = {8'hC0, 24'(head[0])};
    assign ch1_data = {8'hC1, 24'(head[1])};
    assign ch2_data = {8'hC2, 24'(head[2])};

    mcdt_arbiter #(.DW(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_en_i    (en),
        .cfg_rr_i    (rr),
        .ch0_req_i   (ch0_req),
        .ch1_req_i   (ch1_req),
        .ch2_req_i   (ch2_req),
        .ch0_data_i  (ch0_data),
        .ch1_data_i  (ch1_data),
        .ch2_data_i  (ch2_data),
        .ch0_ack_o   (ch0_ack),
        .ch1_ack_o   (ch1_ack),
        .ch2_ack_o   (ch2_ack),
        .mcdt_rdy_i  (rdy),
        .mcdt_data_o (mcdt_data),
        .mcdt_val_o  (mcdt_val),
        .mcdt_id_o   (mcdt_id)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: contents of the output slot and the last winner.
    bit          m_val  = 1'b0;
    logic [31:0] m_data = '0;
    int          m_id   = 0;
    int          m_last = 2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: predict and check the ack at mid-cycle, then check the
    // registered outputs just after the edge and pop the granted FIFO.
    task automatic step();
        int          g;
        bit          free;
        bit          r;
        logic [31:0] gd;
        @(negedge clk);
        r    = rst;
        g    = -1;
        gd   = '0;
        free = !m_val || rdy;
        if (!r && free) begin
            if (rr) begin
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_last + k) % 3;
                    if (g < 0 && cnt[c] > 0 && en[c]) g = c;
                end
            end else begin
                for (int c = 0; c < 3; c++)
                    if (g < 0 && cnt[c] > 0 && en[c]) g = c;
            end
        end
        chk("ack0", 64'(ch0_ack), 64'(g == 0));
        chk("ack1", 64'(ch1_ack), 64'(g == 1));
        chk("ack2", 64'(ch2_ack), 64'(g == 2));
        if (g >= 0) gd = {8'(8'hC0 + g), 24'(head[g])};
        @(posedge clk);
        #1;
        if (r) begin
            m_val = 1'b0; m_data = '0; m_id = 0; m_last = 2;
        end else if (g >= 0) begin
            m_val = 1'b1; m_data = gd; m_id = g; m_last = g;
            cnt[g]--;
            head[g]++;
        end else if (free) begin
            m_val = 1'b0;
        end
        chk("val",  64'(mcdt_val),  64'(m_val));
        chk("id",   64'(mcdt_id),   64'(m_id));
        chk("data", 64'(mcdt_data), 64'(m_data));
    endtask

    task automatic fill(input int c0, input int c1, input int c2);
        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2;
    endtask

    initial begin
        for (int c = 0; c < 3; c++) begin cnt[c] = 0; head[c] = 0; end
        rst = 1'b1; rr = 1'b1; rdy = 1'b1; en = 3'b111;

        // Reset, then a single channel with four words.
        for (int i = 0; i < 10; i++) step();
        chk("rst_val",  64'(mcdt_val),  64'd0);
        chk("rst_data", 64'(mcdt_data), 64'd0);
        chk("rst_id",   64'(mcdt_id),   64'd0);
        rst = 1'b0;
        fill(0, 4, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_data", 64'(mcdt_data), 64'(32'hC100_0000 + i));
            chk("t1_id",   64'(mcdt_id),   64'd1);
        end
        step();
        chk("t1_idle", 64'(mcdt_val), 64'd0);

        // Round-robin with everyone requesting, from a fresh reset.
        rst = 1'b1; step(); rst = 1'b0;
        fill(20, 20, 20);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_id", 64'(mcdt_id), 64'(i % 3));
        end

        // Fixed priority: ch0 wins until it empties, then ch1 every cycle.
        rr = 1'b0;
        fill(3, 10, 10);
        for (int i = 0; i < 3; i++) begin step(); chk("fp_ch0", 64'(mcdt_id), 64'd0); end
        for (int i = 0; i < 3; i++) begin step(); chk("fp_ch1", 64'(mcdt_id), 64'd1); end

        // Back-pressure on a ch2 word.
        rst = 1'b1; step(); rst = 1'b0;
        rr = 1'b1;
        fill(0, 0, 3);
        head[2] = 5;
        step();
        chk("bp_load", 64'(mcdt_data), 64'h0000_0000_C200_0005);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_data", 64'(mcdt_data), 64'h0000_0000_C200_0005);
            chk("bp_id",   64'(mcdt_id),   64'd2);
            chk("bp_val",  64'(mcdt_val),  64'd1);
        end
        rdy = 1'b1;
        step();
        chk("bp_next", 64'(mcdt_data), 64'h0000_0000_C200_0006);

        // Enable masking, then a round-robin -> fixed switch mid-stream.
        rst = 1'b1; step(); rst = 1'b0;
        en = 3'b101;
        fill(10, 10, 10);
        step(); chk("msk_a", 64'(mcdt_id), 64'd0);
        step(); chk("msk_b", 64'(mcdt_id), 64'd2);
        step(); chk("msk_c", 64'(mcdt_id), 64'd0);
        rr = 1'b0;
        step(); chk("sw_fixed", 64'(mcdt_id), 64'd0);

        // Reset while a word is stalled in the output slot.
        rdy = 1'b0;
        step();
        chk("mr_pre", 64'(mcdt_val), 64'd1);
        rst = 1'b1;
        step();
        chk("mr_val", 64'(mcdt_val), 64'd0);
        rst = 1'b0; rdy = 1'b1; rr = 1'b1; en = 3'b111;
        step();
        chk("mr_first", 64'(mcdt_id), 64'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) en = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) rr = 1'($urandom_range(0, 1));
            for (int c = 0; c < 3; c++)
                if (cnt[c] == 0 && $urandom_range(0, 3) == 0) cnt[c] = $urandom_range(1, 6);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mcdt_arbiter.md
# mcdt_arbiter

Three-channel output arbiter for the MCDT datapath. Sits between the three per-channel slave FIFOs and the single MCDT output port. Each cycle it selects one requesting, enabled channel, pops one word from that channel's FIFO and presents the word on the registered output with its channel id. Arbitration is round-robin or fixed-priority, and the output honours downstream back-pressure.

## Interface
Parameters:
- DW, 32, data width of every channel and of the output.

Ports:
- clk_i  in  1  sole clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cfg_en_i  in  3  per-channel enable; bit n gates channel n.
- cfg_rr_i  in  1  1 = round-robin, 0 = fixed priority (ch0 > ch1 > ch2).
- ch0_req_i / ch1_req_i / ch2_req_i  in  1 each  channel FIFO non-empty.
- ch0_data_i / ch1_data_i / ch2_data_i  in  DW each  channel FIFO head word.
- ch0_ack_o / ch1_ack_o / ch2_ack_o  out  1 each  pop strobe to the channel FIFO; combinational, one-hot or zero.
- mcdt_rdy_i  in  1  downstream ready.
- mcdt_data_o  out  DW  output word, registered.
- mcdt_val_o  out  1  output word valid, registered.
- mcdt_id_o  out  2  source channel of mcdt_data_o (0..2), registered.

## Operation
- Eligible channels: elig[n] = chn_req_i & cfg_en_i[n].
- Slot free: free = !mcdt_val_o | mcdt_rdy_i.
- Grant: when free and elig != 0, exactly one chn_ack_o is high this cycle. Otherwise all ack outputs are 0.
- Fixed mode: grant goes to the lowest eligible index.
- Round-robin mode: search order starts at last_grant+1 mod 3 and wraps (2 → 0). Grant goes to the first eligible channel in that order.
- last_grant register (2 bits, values 0..2): updates to the granted index only on a grant. It also updates in fixed mode, so a later switch to round-robin continues from the most recent winner.
- On a grant edge: mcdt_data_o <= granted chn_data_i, mcdt_id_o <= index, mcdt_val_o <= 1.
- On an edge with free = 1 and no grant: mcdt_val_o <= 0. mcdt_data_o and mcdt_id_o hold.
- On an edge with free = 0 (stall): all output registers hold, so data and id stay stable while valid is high and ready is low.
- A transfer completes on any edge where mcdt_val_o & mcdt_rdy_i. A new word may be loaded on that same edge, giving full throughput of one word per cycle.
- cfg_en_i and cfg_rr_i are sampled combinationally every cycle. A change takes effect at the next arbitration decision. A word already in the output register is never revoked.
- A disabled channel with a pending request is never acked. Its FIFO contents remain untouched.

## Timing
- Reset values (edge with rst_i = 1):
  - mcdt_val_o = 0, mcdt_data_o = 0, mcdt_id_o = 0.
  - last_grant = 2, so ch0 is searched first after reset.
  - While rst_i = 1, all chn_ack_o = 0 combinationally.
- Reset mid-operation: the pending output word is discarded (mcdt_val_o = 0 after the edge). Ack is suppressed in the reset cycle, so no FIFO pop is lost.
- Latency: ack in cycle T, word visible on mcdt_* from edge T+1.
- Throughput: with mcdt_rdy_i held at 1 and requests present, one grant per cycle.
- Round-robin fairness: with all three channels continuously eligible, grants rotate 0, 1, 2, 0, … and no channel waits more than 2 grants.
- Simultaneous events: ready rising while a stall is held gives a grant in that same cycle (free = 1). A request that drops in the same cycle as its ack is the FIFO's concern; the arbiter treats req as valid for that cycle.

## Test plan
- Reset then single channel: rst_i for 10 cycles; ch1 requests 4 words 0xC1000000..03, mcdt_rdy_i = 1. Required: ch1_ack_o high 4 cycles; output shows the 4 words with id = 1 one cycle later; then val = 0.
- Round-robin, all requesting: cfg_rr_i = 1, cfg_en_i = 3'b111, all req held high for 6 grants. Required: mcdt_id_o sequence 0, 1, 2, 0, 1, 2.
- Fixed priority: cfg_rr_i = 0, all requesting. Required: only ch0 acked while ch0_req_i = 1; after ch0 drops, ch1 is acked every cycle.
- Back-pressure: word 0xC2000005 loaded, mcdt_rdy_i = 0 for 5 cycles. Required: data, id = 2 and val stable; no ack during the stall; on ready = 1, the next grant occurs in that same cycle.
- Enable masking and mode switch: cfg_en_i = 3'b101 with all requesting. Required: ch1 is never acked and ids alternate 0, 2. Switch cfg_rr_i 1 → 0 mid-stream: the next grant is ch0.
- Reset mid-stream: assert rst_i while val = 1 and ready = 0. Required: val = 0 after the edge, no ack during reset, and the first grant after reset goes to ch0.
